// File: rtl/regfile_pkg.sv
// Shared types and constants for the multiport register file.
// Imported by the storage top and the busy-bit scoreboard.
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int WORD_W = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0] reg_word_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending flag per architectural register.
// Flush beats reserve, reserve beats a same-cycle write-back clear.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WRITE-1:0]           we,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wa,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  ra,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  input  logic                           flush,
  output logic [NUM_READ-1:0]            busy,
  output logic                           any_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZA =
    ADDR_WIDTH'(ZERO_ADDR);

  logic [DEPTH-1:0] bits;
  logic [DEPTH-1:0] bits_nxt;
  logic             rsv_ok;

  assign rsv_ok = rsv_en &&
    !(ZERO_REG != 0 && rsv_addr == ZA);

  always_comb begin
    bits_nxt = bits;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (we[j])
        bits_nxt[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (rsv_ok)
      bits_nxt[rsv_addr] = 1'b1;
    if (flush)
      bits_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bits <= '0;
    else
      bits <= bits_nxt;
  end

  assign any_busy = |bits;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;

    assign addr = ra[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      hit = 1'b0;
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (we[j] &&
            wa[j*ADDR_WIDTH +: ADDR_WIDTH] == addr)
          hit = 1'b1;
      end
    end

    assign busy[i] = bits[addr]
      && !(BYPASS != 0 && hit)
      && !(ZERO_REG != 0 && addr == ZA);
  end

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised N-read/M-write register file with optional bypass
// and an integrated operand scoreboard for decode-stage hazards.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_WRITE-1:0]            we,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WRITE*WORD_WIDTH-1:0] wd,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  ra,
  output logic [NUM_READ*WORD_WIDTH-1:0]  rd,
  output logic [NUM_READ-1:0]             busy,
  input  logic                            rsv_en,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr,
  input  logic                            flush,
  output logic                            any_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZA =
    ADDR_WIDTH'(ZERO_ADDR);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Ascending port order makes the highest port win a collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (we[j] &&
            !(ZERO_REG != 0 &&
              wa[j*ADDR_WIDTH +: ADDR_WIDTH] == ZA))
          mem[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] <=
            wd[j*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] val;

    assign addr = ra[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      val = mem[addr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (we[j] &&
              wa[j*ADDR_WIDTH +: ADDR_WIDTH] == addr)
            val = wd[j*WORD_WIDTH +: WORD_WIDTH];
        end
      end
      if (ZERO_REG != 0 && addr == ZA)
        val = '0;
    end

    assign rd[i*WORD_WIDTH +: WORD_WIDTH] = val;
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .NUM_WRITE  (NUM_WRITE),
    .BYPASS     (BYPASS),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wa       (wa),
    .ra       (ra),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .busy     (busy),
    .any_busy (any_busy)
  );

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: bypass and non-bypass instances share
// stimulus; directed table, reset sequence, then random vs model.
module tb_multiport_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  we = '0;
  logic [9:0]  wa = '0;
  logic [63:0] wd = '0;
  logic [9:0]  ra = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic        flush = 1'b0;

  logic [63:0] rd_b, rd_n;
  logic [1:0]  busy_b, busy_n;
  logic        any_b, any_n;

  always #5 clk = ~clk;

  multiport_regfile #(
    .ADDR_WIDTH(5), .WORD_WIDTH(32), .NUM_READ(2),
    .NUM_WRITE(2), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_b), .busy(busy_b), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .any_busy(any_b)
  );

  multiport_regfile #(
    .ADDR_WIDTH(5), .WORD_WIDTH(32), .NUM_READ(2),
    .NUM_WRITE(2), .BYPASS(0), .ZERO_REG(1)
  ) dut_nb (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_n), .busy(busy_n), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .any_busy(any_n)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_mem [32];
  bit          m_sb  [32];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got %h want %h",
                  nm, idx, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_mem[k] = '0;
      m_sb[k]  = 1'b0;
    end
  endtask

  function automatic bit hits(input logic [4:0] a);
    bit h = 0;
    for (int j = 0; j < 2; j++)
      if (we[j] && wa[j*5 +: 5] == a) h = 1;
    return h;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                         input bit byp);
    logic [31:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
    if (byp)
      for (int j = 0; j < 2; j++)
        if (we[j] && wa[j*5 +: 5] == a) v = wd[j*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a,
                                    input bit byp);
    if (a == 0) return 1'b0;
    if (byp && hits(a)) return 1'b0;
    return m_sb[a];
  endfunction

  function automatic logic exp_any();
    logic r = 1'b0;
    for (int k = 0; k < 32; k++) r |= m_sb[k];
    return r;
  endfunction

  task automatic model_update();
    if (!reset) return;
    for (int j = 0; j < 2; j++)
      if (we[j] && wa[j*5 +: 5] != 0)
        m_mem[wa[j*5 +: 5]] = wd[j*32 +: 32];
    if (flush) begin
      for (int k = 0; k < 32; k++) m_sb[k] = 1'b0;
    end else begin
      for (int j = 0; j < 2; j++)
        if (we[j]) m_sb[wa[j*5 +: 5]] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_sb[rsv_addr] = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_rd_b"}, i, rd_b[i*32 +: 32],
          exp_rd(ra[i*5 +: 5], 1));
      chk({tag, "_rd_n"}, i, rd_n[i*32 +: 32],
          exp_rd(ra[i*5 +: 5], 0));
      chk({tag, "_busy_b"}, i, 32'(busy_b[i]),
          32'(exp_busy(ra[i*5 +: 5], 1)));
      chk({tag, "_busy_n"}, i, 32'(busy_n[i]),
          32'(exp_busy(ra[i*5 +: 5], 0)));
    end
    chk({tag, "_any_b"}, 0, 32'(any_b), 32'(exp_any()));
    chk({tag, "_any_n"}, 0, 32'(any_n), 32'(exp_any()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic [31:0] e_rd0;
    logic [31:0] e_rd0_nb;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_any;
  } vec_t;

  vec_t vt [19];

  initial begin
    vt[0]  = '{2'b01, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 2'b00, 0};
    vt[1]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 2'b00, 0};
    vt[2]  = '{2'b01, 3, 32'hA5A5A5A5, 0, 0, 3, 0, 0, 0, 0,
               32'hA5A5A5A5, 0, 0, 2'b00, 0};
    vt[3]  = '{2'b00, 0, 0, 0, 0, 3, 0, 0, 0, 0,
               32'hA5A5A5A5, 32'hA5A5A5A5, 0, 2'b00, 0};
    vt[4]  = '{2'b11, 9, 32'h1, 9, 32'h2, 9, 3, 0, 0, 0,
               32'h2, 0, 32'hA5A5A5A5, 2'b00, 0};
    vt[5]  = '{2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 0,
               32'h2, 32'h2, 0, 2'b00, 0};
    vt[6]  = '{2'b00, 0, 0, 0, 0, 4, 9, 1, 4, 0,
               0, 0, 32'h2, 2'b00, 0};
    vt[7]  = '{2'b00, 0, 0, 0, 0, 4, 0, 0, 0, 0,
               0, 0, 0, 2'b01, 1};
    vt[8]  = '{2'b01, 4, 32'h44, 0, 0, 4, 0, 0, 0, 0,
               32'h44, 0, 0, 2'b00, 1};
    vt[9]  = '{2'b00, 0, 0, 0, 0, 4, 0, 0, 0, 0,
               32'h44, 32'h44, 0, 2'b00, 0};
    vt[10] = '{2'b01, 6, 32'h66, 0, 0, 6, 0, 1, 6, 0,
               32'h66, 0, 0, 2'b00, 0};
    vt[11] = '{2'b00, 0, 0, 0, 0, 6, 0, 0, 0, 0,
               32'h66, 32'h66, 0, 2'b01, 1};
    vt[12] = '{2'b00, 0, 0, 0, 0, 6, 1, 1, 1, 0,
               32'h66, 32'h66, 0, 2'b01, 1};
    vt[13] = '{2'b00, 0, 0, 0, 0, 1, 2, 1, 2, 0,
               0, 0, 0, 2'b01, 1};
    vt[14] = '{2'b00, 0, 0, 0, 0, 2, 3, 1, 3, 0,
               0, 0, 32'hA5A5A5A5, 2'b01, 1};
    vt[15] = '{2'b00, 0, 0, 0, 0, 3, 8, 1, 8, 1,
               32'hA5A5A5A5, 32'hA5A5A5A5, 0, 2'b01, 1};
    vt[16] = '{2'b00, 0, 0, 0, 0, 6, 8, 0, 0, 0,
               32'h66, 32'h66, 0, 2'b00, 0};
    vt[17] = '{2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0,
               0, 0, 0, 2'b00, 0};
    vt[18] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 2'b00, 0};

    model_reset();
    #2;
    check_model("rst");
    #10 reset = 1'b1;
    tick();

    // Reset asserted mid-cycle must clear storage with no clock edge.
    we = 2'b11; wa = {5'd7, 5'd5};
    wd = {32'hDEADBEEF, 32'hDEADBEEF};
    tick();
    we = 2'b00; ra = {5'd7, 5'd5};
    #2;
    chk("pre_rst_rd0", 0, rd_b[31:0], 32'hDEADBEEF);
    chk("pre_rst_rd1", 1, rd_b[63:32], 32'hDEADBEEF);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_rd0", 0, rd_b[31:0], 32'h0);
    chk("async_rst_rd1", 1, rd_b[63:32], 32'h0);
    chk("async_rst_nb_rd0", 0, rd_n[31:0], 32'h0);
    check_model("async_rst");
    #2 reset = 1'b1;
    tick();

    for (int r = 0; r < 19; r++) begin
      we = vt[r].we;
      wa = {vt[r].wa1, vt[r].wa0};
      wd = {vt[r].wd1, vt[r].wd0};
      ra = {vt[r].ra1, vt[r].ra0};
      rsv_en = vt[r].rsv_en;
      rsv_addr = vt[r].rsv_addr;
      flush = vt[r].flush;
      #3;
      chk("t_rd0", r, rd_b[31:0], vt[r].e_rd0);
      chk("t_rd0_nb", r, rd_n[31:0], vt[r].e_rd0_nb);
      chk("t_rd1", r, rd_b[63:32], vt[r].e_rd1);
      chk("t_busy", r, 32'(busy_b), 32'(vt[r].e_busy));
      chk("t_any", r, 32'(any_b), 32'(vt[r].e_any));
      check_model("t_model");
      tick();
    end

    for (int c = 0; c < 400; c++) begin
      we = 2'($urandom);
      wa = {5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15))};
      wd = {$urandom, $urandom};
      ra = {5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15))};
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      #3;
      check_model("rnd");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised register file for the pipelined RISC-V core. It supersedes the fixed two-read/one-write register file and adds four things: configurable read and write port counts, asynchronous reset of all storage, optional write-to-read bypass, and an integrated busy-bit scoreboard. The scoreboard lets the decode stage detect operands whose producing instruction has not yet written back. The block sits between decode (reads, reservations) and writeback (writes).

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2^ADDR_WIDTH.
- WORD_WIDTH, 32, data width.
- NUM_READ, 2, read ports (1..4).
- NUM_WRITE, 1, write ports (1..2).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads.
- ZERO_REG, 1, 1 = index 0 hardwired to zero, never busy.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- we  in  NUM_WRITE  per-port write enable.
- wa  in  NUM_WRITE×ADDR_WIDTH  write addresses (packed, port 0 in LSBs).
- wd  in  NUM_WRITE×WORD_WIDTH  write data.
- ra  in  NUM_READ×ADDR_WIDTH  read addresses.
- rd  out  NUM_READ×WORD_WIDTH  read data, combinational.
- busy  out  NUM_READ  per read port: operand pending.
- rsv_en  in  1  reserve destination (mark busy).
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- flush  in  1  clear all busy bits (pipeline flush).
- any_busy  out  1  OR of all busy bits.

## Operation
- Reset (reset=0, asynchronous): all registers = 0, all busy bits = 0. Consequently rd = 0, busy = 0, any_busy = 0.
- Write: at each rising edge, for every port with we=1, the register at wa takes wd.
  - Two write ports targeting the same address: the higher port index wins.
  - When ZERO_REG=1, writes to address 0 are discarded.
- Read:
  - rd[i] = storage[ra[i]].
  - When ZERO_REG=1 and ra[i]=0, rd[i] = 0 regardless of any write.
  - When BYPASS=1 and some we[j]=1 with wa[j]=ra[i] in the same cycle, rd[i] = wd of the highest such j.
- Scoreboard, per-register busy bit, next-state priority:
  1. flush=1 → all bits 0; rsv_en is ignored that cycle.
  2. Otherwise rsv_en=1 sets bit[rsv_addr]. This includes the case where a write to the same address occurs in the same cycle: the new producer wins.
  3. A write (we[j]=1) clears bit[wa[j]] unless rule 2 sets that bit.
  4. When ZERO_REG=1, a reservation of address 0 is ignored.
- busy output:
  - busy[i] = bit[ra[i]].
  - When BYPASS=1, busy[i] is masked to 0 if a same-cycle write hits ra[i].
  - busy is 0 for address 0 when ZERO_REG=1.

## Timing
- Read latency: 0 cycles (combinational from ra, and from we/wa/wd when BYPASS=1).
- Write-to-read latency: the value appears in the cycle after the edge, or in the same cycle when BYPASS=1.
- Reserve to busy visible: the cycle after the rsv_en edge.
- Write to busy clear: the cycle after the write edge, or the same cycle via the mask when BYPASS=1.
- Reset assertion mid-operation clears state immediately, with no clock required. Deassertion is synchronised externally; the first write is accepted on the first rising edge with reset=1.
- Writing and reading the same address with BYPASS=0 returns the old value that cycle.

## Structure
- Package regfile_pkg holds:
  - typedefs reg_addr_t and reg_word_t, sized by the package defaults.
  - the constant ZERO_ADDR.
- Sub-module rf_scoreboard contains the busy-bit array, the priority next-state logic, and any_busy. It is instantiated once.
- Storage array, write arbitration and bypass muxing stay in multiport_regfile.

## Test plan
- Reset/zero reads:
  - Write 0xDEADBEEF to x5 and x7, then pulse reset=0 mid-cycle → rd = 0 for x5 and x7 immediately.
  - Write 0x1234 to x0 → rd(x0) = 0.
- Bypass (BYPASS=1):
  - Same cycle we=1, wa=3, wd=0xA5A5A5A5, ra[0]=3 → rd[0] = 0xA5A5A5A5 that cycle.
  - With BYPASS=0, the same stimulus → rd[0] = old value (0) that cycle, then 0xA5A5A5A5 the next cycle.
- Write conflict (NUM_WRITE=2): both ports write x9, with wd0=0x1 and wd1=0x2 → rd(x9) = 0x2 afterwards.
- Scoreboard basic:
  - rsv_en, rsv_addr=4 → next cycle busy=1 for ra=4 and any_busy=1.
  - Write x4 → busy=0 in the same cycle (BYPASS=1) and bit clear after the edge.
- Scoreboard simultaneous: rsv_en with rsv_addr=6 plus a write to x6 in the same cycle → busy stays 1 after the edge.
- Flush: reserve x1, x2 and x3, then assert flush together with rsv_en for x8 → all busy bits = 0 and any_busy = 0 next cycle.
